sr_cpu_core: RTL and testbench



---
 rtl/sr_cpu_core_if.sv | 21 ++
 rtl/sr_cpu_core.sv | 212 +++++++++++++++++++++
 tb/tb_sr_cpu_core.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cpu_core_if.sv
// Shared single-port memory bus between the core (master) and a 512x16 memory (slave).
interface sr_cpu_core_if;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;

    modport master (
        input  read_data,
        output mem_cmd,
        output mem_addr,
        output write_data
    );

    modport slave (
        output read_data,
        input  mem_cmd,
        input  mem_addr,
        input  write_data
    );
endinterface

// File: rtl/sr_cpu_core.sv
// Multicycle 16-bit load/store core: decoder, control FSM, 8x16 register file, shifter/ALU,
// flags, PC and data-address register sharing one memory port for fetch and data.
module sr_cpu_core (
    input  logic          clk,
    input  logic          reset,
    sr_cpu_core_if.master mem,
    output logic [15:0]   out,
    output logic          N,
    output logic          V,
    output logic          Z
);
    typedef enum logic [4:0] {
        StRst, StIf1, StIf2, StUpc, StDec, StWimm, StGeta, StGetb, StExec,
        StWr, StAddr, StLda, StMem1, StMem2, StSdat, StMemw, StHalt
    } state_e;

    localparam logic [1:0] CmdNone  = 2'b00;
    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d;
    logic [8:0]  pc_q, pc_d, da_q, da_d;
    logic        n_q, n_d, v_q, v_d, z_q, z_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        addr_sel_q, addr_sel_d;
    logic [15:0] rf_q [8];
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, shift;
    logic [15:0] sximm8, sximm5, sh_b, alu_a, alu_b, alu_y;
    logic        is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str, is_halt, is_mem;

    assign opcode  = ir_q[15:13];
    assign op      = ir_q[12:11];
    assign rn      = ir_q[10:8];
    assign rd      = ir_q[7:5];
    assign rm      = ir_q[2:0];
    assign sximm8  = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5  = {{11{ir_q[4]}}, ir_q[4:0]};
    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt = (opcode == 3'b111);
    assign is_mem  = is_ldr || is_str;
    // Bits [4:3] of LDR/STR are immediate bits, not a shift code.
    assign shift   = is_mem ? 2'b00 : ir_q[4:3];

    always_comb begin
        case (shift)
            2'b01:   sh_b = {b_q[14:0], 1'b0};
            2'b10:   sh_b = {1'b0, b_q[15:1]};
            2'b11:   sh_b = {b_q[15], b_q[15:1]};
            default: sh_b = b_q;
        endcase
        alu_a = (is_movr || state_q == StSdat) ? 16'h0000 : a_q;
        alu_b = (state_q == StAddr) ? sximm5 : sh_b;
        alu_y = alu_a + alu_b;
        if (state_q == StExec && is_alu) begin
            case (op)
                2'b01:   alu_y = alu_a - alu_b;
                2'b10:   alu_y = alu_a & alu_b;
                2'b11:   alu_y = ~alu_b;
                default: alu_y = alu_a + alu_b;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        pc_d     = pc_q;
        da_d     = da_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = c_q;
        case (state_q)
            StRst: state_d = StIf1;
            StIf1: state_d = StIf2;
            StIf2: begin
                ir_d    = mem.read_data;
                state_d = StUpc;
            end
            StUpc: begin
                pc_d    = pc_q + 9'd1;
                state_d = StDec;
            end
            StDec: begin
                if (is_movi)                          state_d = StWimm;
                else if (is_movr || is_mvn)           state_d = StGetb;
                else if (is_alu || is_mem)            state_d = StGeta;
                else if (is_halt)                     state_d = StHalt;
                else                                  state_d = StIf1;
            end
            StWimm: begin
                rf_we    = 1'b1;
                rf_waddr = rn;
                rf_wdata = sximm8;
                state_d  = StIf1;
            end
            StGeta: begin
                a_d     = rf_q[rn];
                state_d = is_mem ? StAddr : StGetb;
            end
            StGetb: begin
                b_d     = rf_q[is_str ? rd : rm];
                state_d = is_str ? StSdat : StExec;
            end
            StExec: begin
                if (is_cmp) begin
                    z_d     = (alu_y == 16'h0000);
                    n_d     = alu_y[15];
                    v_d     = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
                    state_d = StIf1;
                end else begin
                    c_d     = alu_y;
                    state_d = StWr;
                end
            end
            StWr: begin
                rf_we   = 1'b1;
                state_d = StIf1;
            end
            StAddr: begin
                c_d     = alu_y;
                state_d = StLda;
            end
            StLda: begin
                da_d    = c_q[8:0];
                state_d = is_ldr ? StMem1 : StGetb;
            end
            StMem1: state_d = StMem2;
            StMem2: begin
                rf_we    = 1'b1;
                rf_wdata = mem.read_data;
                state_d  = StIf1;
            end
            StSdat: begin
                c_d     = alu_y;
                state_d = StMemw;
            end
            StMemw:  state_d = StIf1;
            StHalt:  state_d = StHalt;
            default: state_d = StRst;
        endcase

        // Bus outputs are registered, so they are decoded from the upcoming state.
        cmd_d      = CmdNone;
        addr_sel_d = 1'b1;
        case (state_d)
            StIf1, StIf2:   cmd_d = CmdRead;
            StMem1, StMem2: begin
                cmd_d      = CmdRead;
                addr_sel_d = 1'b0;
            end
            StMemw: begin
                cmd_d      = CmdWrite;
                addr_sel_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRst;
            pc_q       <= 9'd0;
            c_q        <= 16'h0000;
            da_q       <= 9'd0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
            z_q        <= 1'b0;
            cmd_q      <= CmdNone;
            addr_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            pc_q       <= pc_d;
            da_q       <= da_d;
            n_q        <= n_d;
            v_q        <= v_d;
            z_q        <= z_d;
            cmd_q      <= cmd_d;
            addr_sel_q <= addr_sel_d;
            if (rf_we) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem.mem_cmd    = cmd_q;
    assign mem.mem_addr   = addr_sel_q ? pc_q : da_q;
    assign mem.write_data = c_q;
    assign out            = c_q;
    assign N              = n_q;
    assign V              = v_q;
    assign Z              = z_q;
endmodule

// File: tb/tb_sr_cpu_core.sv
// Directed bench for sr_cpu_core: small programs in a modelled 512x16 memory, bus trace per cycle.
module tb_sr_cpu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] out;
    logic        n_flag, v_flag, z_flag;

    sr_cpu_core_if mif ();

    sr_cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .mem   (mif),
        .out   (out),
        .N     (n_flag),
        .V     (v_flag),
        .Z     (z_flag)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [512];
    initial mif.read_data = 16'h0000;

    always @(posedge clk) begin
        if (mif.mem_cmd == 2'b10) mem[mif.mem_addr] <= mif.write_data;
        if (mif.mem_cmd == 2'b01) mif.read_data <= mem[mif.mem_addr];
    end

    // Per-cycle trace; index 0 is the first cycle after reset is released (IF1).
    logic [1:0]  cmd_log  [128];
    logic [8:0]  addr_log [128];
    logic [15:0] wd_log   [128];
    logic [15:0] out_log  [128];
    logic [2:0]  nvz_log  [128];
    int n = 0;

    always @(posedge clk) begin
        #1;
        if (!reset && n < 128) begin
            cmd_log[n]  = mif.mem_cmd;
            addr_log[n] = mif.mem_addr;
            wd_log[n]   = mif.write_data;
            out_log[n]  = out;
            nvz_log[n]  = {n_flag, v_flag, z_flag};
            n++;
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] movi(input logic [2:0] r, input logic [7:0] imm);
        return {3'b110, 2'b10, r, imm};
    endfunction
    function automatic logic [15:0] movr(input logic [2:0] d, input logic [1:0] sh,
                                         input logic [2:0] m);
        return {3'b110, 2'b00, 3'b000, d, sh, m};
    endfunction
    function automatic logic [15:0] alu(input logic [1:0] o, input logic [2:0] r,
                                        input logic [2:0] d, input logic [1:0] sh,
                                        input logic [2:0] m);
        return {3'b101, o, r, d, sh, m};
    endfunction
    function automatic logic [15:0] ldr(input logic [2:0] d, input logic [2:0] r,
                                        input logic [4:0] imm);
        return {3'b011, 2'b00, r, d, imm};
    endfunction
    function automatic logic [15:0] str(input logic [2:0] d, input logic [2:0] r,
                                        input logic [4:0] imm);
        return {3'b100, 2'b00, r, d, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    task automatic start_run();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n     = 0;
        reset = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mif.mem_cmd !== 2'b00) begin errors++;
            $display("FAIL reset_cmd got %b exp 00", mif.mem_cmd); end
        checks++; if (mif.mem_addr !== 9'd0) begin errors++;
            $display("FAIL reset_addr got %0d exp 0", mif.mem_addr); end
        checks++; if (out !== 16'h0000) begin errors++;
            $display("FAIL reset_out got %h exp 0000", out); end
        checks++; if ({n_flag, v_flag, z_flag} !== 3'b000) begin errors++;
            $display("FAIL reset_flags got %b exp 000", {n_flag, v_flag, z_flag}); end
    endtask

    task automatic test_mov_imm();
        clear_mem();
        mem[0] = 16'hD0FD;
        mem[1] = 16'hE000;
        start_run();
        run(20);
        checks++; if (cmd_log[0] !== 2'b01 || addr_log[0] !== 9'd0) begin errors++;
            $display("FAIL fetch0 got cmd %b addr %0d exp 01/0", cmd_log[0], addr_log[0]); end
        checks++; if (cmd_log[5] !== 2'b01 || addr_log[5] !== 9'd1) begin errors++;
            $display("FAIL fetch1 got cmd %b addr %0d exp 01/1", cmd_log[5], addr_log[5]); end
        checks++; if (cmd_log[12] !== 2'b00 || addr_log[12] !== 9'd2) begin errors++;
            $display("FAIL halt_early got cmd %b addr %0d exp 00/2", cmd_log[12], addr_log[12]); end
        checks++; if (cmd_log[19] !== 2'b00 || addr_log[19] !== 9'd2) begin errors++;
            $display("FAIL halt_late got cmd %b addr %0d exp 00/2", cmd_log[19], addr_log[19]); end
        // Expose R0 through MOV R1,R0.
        clear_mem();
        mem[0] = 16'hD0FD;
        mem[1] = movr(3'd1, 2'b00, 3'd0);
        mem[2] = 16'hE000;
        start_run();
        run(15);
        checks++; if (out_log[11] !== 16'hFFFD) begin errors++;
            $display("FAIL movi_r0 got %h exp FFFD", out_log[11]); end
    endtask

    task automatic test_add_lsl();
        clear_mem();
        mem[0] = movi(3'd1, 8'd5);
        mem[1] = movi(3'd2, 8'd3);
        mem[2] = alu(2'b00, 3'd1, 3'd3, 2'b01, 3'd2);
        mem[3] = str(3'd3, 3'd1, 5'd0);
        mem[4] = 16'hE000;
        start_run();
        run(35);
        checks++; if (cmd_log[10] !== 2'b01 || addr_log[10] !== 9'd2) begin errors++;
            $display("FAIL add_if1 got cmd %b addr %0d exp 01/2", cmd_log[10], addr_log[10]); end
        checks++; if (out_log[16] !== 16'h0000) begin errors++;
            $display("FAIL add_exec_out got %h exp 0000", out_log[16]); end
        checks++; if (out_log[17] !== 16'd11) begin errors++;
            $display("FAIL add_wr_out got %h exp 000b", out_log[17]); end
        checks++; if (cmd_log[17] !== 2'b00) begin errors++;
            $display("FAIL add_wr_cmd got %b exp 00", cmd_log[17]); end
        checks++; if (cmd_log[18] !== 2'b01 || addr_log[18] !== 9'd3) begin errors++;
            $display("FAIL add_8cyc got cmd %b addr %0d exp 01/3", cmd_log[18], addr_log[18]); end
        checks++; if (mem[5] !== 16'd11) begin errors++;
            $display("FAIL add_r3 got %h exp 000b", mem[5]); end
    endtask

    task automatic test_cmp_flags();
        clear_mem();
        mem[0]  = movi(3'd0, 8'd5);
        mem[1]  = movi(3'd1, 8'd5);
        mem[2]  = alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1);
        mem[3]  = movi(3'd2, 8'd3);
        mem[4]  = alu(2'b01, 3'd2, 3'd0, 2'b00, 3'd1);
        mem[5]  = movi(3'd3, 8'hFF);
        mem[6]  = movr(3'd3, 2'b10, 3'd3);
        mem[7]  = alu(2'b11, 3'd0, 3'd3, 2'b00, 3'd3);
        mem[8]  = movi(3'd4, 8'd1);
        mem[9]  = alu(2'b01, 3'd3, 3'd0, 2'b00, 3'd4);
        mem[10] = alu(2'b00, 3'd3, 3'd5, 2'b00, 3'd3);
        mem[11] = 16'hE000;
        start_run();
        run(80);
        checks++; if (nvz_log[17] !== 3'b001) begin errors++;
            $display("FAIL cmp_eq nvz got %b exp 001", nvz_log[17]); end
        checks++; if (nvz_log[29] !== 3'b100) begin errors++;
            $display("FAIL cmp_lt nvz got %b exp 100", nvz_log[29]); end
        checks++; if (out_log[47] !== 16'h8000) begin errors++;
            $display("FAIL build_8000 got %h exp 8000", out_log[47]); end
        checks++; if (nvz_log[60] !== 3'b010) begin errors++;
            $display("FAIL cmp_ovf nvz got %b exp 010", nvz_log[60]); end
        checks++; if (out_log[67] !== 16'h0000) begin errors++;
            $display("FAIL add_wrap got %h exp 0000", out_log[67]); end
        checks++; if (nvz_log[70] !== 3'b010) begin errors++;
            $display("FAIL add_keeps_flags nvz got %b exp 010", nvz_log[70]); end
    endtask

    task automatic test_str_ldr();
        clear_mem();
        mem[0]  = movi(3'd0, 8'd20);
        mem[1]  = movi(3'd1, 8'd7);
        mem[2]  = str(3'd1, 3'd0, 5'd1);
        mem[3]  = ldr(3'd2, 3'd0, 5'h1F);
        mem[4]  = str(3'd2, 3'd0, 5'd2);
        mem[5]  = 16'hE000;
        mem[19] = 16'hBEEF;
        start_run();
        run(50);
        checks++; if (cmd_log[19] !== 2'b10 || addr_log[19] !== 9'd21) begin errors++;
            $display("FAIL str_bus got cmd %b addr %0d exp 10/21", cmd_log[19], addr_log[19]); end
        checks++; if (wd_log[19] !== 16'd7) begin errors++;
            $display("FAIL str_data got %h exp 0007", wd_log[19]); end
        checks++; if (cmd_log[27] !== 2'b01 || addr_log[27] !== 9'd19) begin errors++;
            $display("FAIL ldr_mem1 got cmd %b addr %0d exp 01/19", cmd_log[27], addr_log[27]); end
        checks++; if (cmd_log[28] !== 2'b01 || addr_log[28] !== 9'd19) begin errors++;
            $display("FAIL ldr_mem2 got cmd %b addr %0d exp 01/19", cmd_log[28], addr_log[28]); end
        checks++; if (cmd_log[38] !== 2'b10 || addr_log[38] !== 9'd22 ||
                      wd_log[38] !== 16'hBEEF) begin errors++;
            $display("FAIL str_r2 got cmd %b addr %0d data %h exp 10/22/BEEF",
                     cmd_log[38], addr_log[38], wd_log[38]); end
        checks++; if (mem[21] !== 16'd7) begin errors++;
            $display("FAIL mem21 got %h exp 0007", mem[21]); end
        checks++; if (mem[22] !== 16'hBEEF) begin errors++;
            $display("FAIL mem22 got %h exp BEEF", mem[22]); end
    endtask

    task automatic test_shift_mvn_and();
        clear_mem();
        mem[0] = movi(3'd7, 8'd0);
        mem[1] = alu(2'b11, 3'd0, 3'd4, 2'b00, 3'd7);
        mem[2] = movr(3'd5, 2'b11, 3'd4);
        mem[3] = movr(3'd6, 2'b10, 3'd4);
        mem[4] = alu(2'b10, 3'd6, 3'd3, 2'b00, 3'd4);
        mem[5] = 16'hE000;
        start_run();
        run(40);
        checks++; if (out_log[11] !== 16'hFFFF) begin errors++;
            $display("FAIL mvn got %h exp FFFF", out_log[11]); end
        checks++; if (out_log[18] !== 16'hFFFF) begin errors++;
            $display("FAIL asr got %h exp FFFF", out_log[18]); end
        checks++; if (out_log[25] !== 16'h7FFF) begin errors++;
            $display("FAIL lsr got %h exp 7FFF", out_log[25]); end
        checks++; if (out_log[33] !== 16'h7FFF) begin errors++;
            $display("FAIL and got %h exp 7FFF", out_log[33]); end
    endtask

    task automatic test_reset_mid_ldr();
        clear_mem();
        mem[0] = movi(3'd2, 8'd9);
        mem[1] = 16'hE000;
        start_run();
        run(10);
        clear_mem();
        mem[0]  = movi(3'd0, 8'd20);
        mem[1]  = ldr(3'd2, 3'd0, 5'd0);
        mem[2]  = 16'hE000;
        mem[20] = 16'h1234;
        start_run();
        repeat (13) @(posedge clk);
        #1;
        checks++; if (mif.mem_cmd !== 2'b01 || mif.mem_addr !== 9'd20) begin errors++;
            $display("FAIL mem1_bus got cmd %b addr %0d exp 01/20", mif.mem_cmd, mif.mem_addr); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mif.mem_cmd !== 2'b00 || mif.mem_addr !== 9'd0) begin errors++;
            $display("FAIL midrst_bus got cmd %b addr %0d exp 00/0", mif.mem_cmd, mif.mem_addr); end
        checks++; if (out !== 16'h0000) begin errors++;
            $display("FAIL midrst_out got %h exp 0000", out); end
        clear_mem();
        mem[0]  = str(3'd2, 3'd0, 5'd1);
        mem[1]  = 16'hE000;
        mem[20] = 16'h1234;
        start_run();
        run(20);
        checks++; if (cmd_log[0] !== 2'b01 || addr_log[0] !== 9'd0) begin errors++;
            $display("FAIL refetch got cmd %b addr %0d exp 01/0", cmd_log[0], addr_log[0]); end
        checks++; if (mem[21] !== 16'd9) begin errors++;
            $display("FAIL rd_unwritten got %h exp 0009", mem[21]); end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add_lsl();
        test_cmp_flags();
        test_str_ldr();
        test_shift_mvn_and();
        test_reset_mid_ldr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
